// File: rtl/activation_drain_scheduler.sv
// activation_drain_scheduler: round-robin drains of NUM_REQ rows into a shared 1-cycle activation core,
// with source-row tagging and a small first-word-fall-through result FIFO.
module activation_drain_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int DATA_WIDTH = 32,
  parameter int COUNT_WIDTH = 16,
  parameter int FIFO_DEPTH = 2,
  parameter int TAG_WIDTH = $clog2(NUM_REQ)
) (
  input  logic                          core_clk,
  input  logic                          resetn,
  input  logic                          start,
  input  logic [7:0]                    cfg_sel_activation,
  input  logic [DATA_WIDTH-1:0]         cfg_alpha,
  input  logic [COUNT_WIDTH-1:0]        cfg_total_features,
  output logic                          busy,
  output logic                          done,
  output logic                          cfg_error,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [7:0]                    act_sel_activation,
  output logic [DATA_WIDTH-1:0]         act_alpha,
  output logic                          act_in_feature_valid,
  output logic [DATA_WIDTH-1:0]         act_in_feature,
  input  logic                          act_feature_valid,
  input  logic [DATA_WIDTH-1:0]         act_feature,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [TAG_WIDTH-1:0]          out_tag
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN, DONE} state_t;
  state_t state;
  logic [COUNT_WIDTH-1:0] total, issued_cnt;
  logic [TAG_WIDTH-1:0] ptr, gnt_idx, tag_pipe;
  logic inflight, any_valid, space, issue, push, pop, drained;
  logic [CW-1:0] count;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [DATA_WIDTH+TAG_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] rows [NUM_REQ];
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_rows
    assign rows[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end
  // scan from farthest to nearest so the first valid row after ptr wins
  always_comb begin
    gnt_idx = '0;
    any_valid = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req_valid[TAG_WIDTH'((int'(ptr) + k) % NUM_REQ)]) begin
        gnt_idx = TAG_WIDTH'((int'(ptr) + k) % NUM_REQ);
        any_valid = 1'b1;
      end
    end
  end
  assign pop = out_valid && out_ready;
  assign push = act_feature_valid;
  // an entry leaving this cycle frees its slot for the result landing two cycles out
  assign space = int'(count) + int'(inflight) - int'(pop) < FIFO_DEPTH;
  assign issue = state == ACTIVE && issued_cnt != total && any_valid && space;
  assign drained = !inflight && (count + CW'(push) == CW'(pop));
  assign req_ready = issue ? NUM_REQ'(1) << gnt_idx : '0;
  assign act_in_feature_valid = issue;
  assign act_in_feature = rows[gnt_idx];
  assign out_valid = count != '0;
  assign {out_data, out_tag} = mem[rd_ptr];
  always_ff @(posedge core_clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      cfg_error <= 1'b0;
      act_sel_activation <= '0;
      act_alpha <= '0;
      total <= '0;
      issued_cnt <= '0;
      ptr <= TAG_WIDTH'(NUM_REQ - 1);
      tag_pipe <= '0;
      inflight <= 1'b0;
    end else begin
      done <= 1'b0;
      cfg_error <= 1'b0;
      inflight <= issue;
      if (issue) begin
        ptr <= gnt_idx;
        tag_pipe <= gnt_idx;
        issued_cnt <= issued_cnt + COUNT_WIDTH'(1);
      end
      case (state)
        IDLE: if (start && cfg_sel_activation > 8'd2) cfg_error <= 1'b1;
          else if (start) begin
            act_sel_activation <= cfg_sel_activation;
            act_alpha <= cfg_alpha;
            total <= cfg_total_features;
            issued_cnt <= '0;
            busy <= cfg_total_features != '0;
            done <= cfg_total_features == '0;
            state <= cfg_total_features == '0 ? DONE : ACTIVE;
          end
        ACTIVE: if (issued_cnt == total) state <= DRAIN;
        DRAIN: if (drained) begin
            state <= DONE;
            busy <= 1'b0;
            done <= 1'b1;
          end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  always_ff @(posedge core_clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      for (int k = 0; k < FIFO_DEPTH; k++) mem[k] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {act_feature, tag_pipe};
        wr_ptr <= wr_ptr == AW'(FIFO_DEPTH - 1) ? '0 : wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr == AW'(FIFO_DEPTH - 1) ? '0 : rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
  // the core must answer exactly one cycle after every issue
  lost_result: assert property (@(posedge core_clk) disable iff (!resetn) inflight |-> act_feature_valid);
endmodule

// File: tb/tb_activation_drain_scheduler.sv
// tb_activation_drain_scheduler: directed layers against a ReLU core model, checked by a grant/output scoreboard.
module tb_activation_drain_scheduler;
  localparam int N = 4, DW = 32, CW = 16, TW = 2;
  logic core_clk = 0, resetn = 0, start = 0, out_ready = 0;
  logic [7:0] cfg_sel_activation = 0;
  logic [DW-1:0] cfg_alpha = 0;
  logic [CW-1:0] cfg_total_features = 0;
  logic busy, done, cfg_error, act_in_feature_valid, act_feature_valid, out_valid;
  logic [N-1:0] req_valid = 0, req_ready, taken;
  logic [N*DW-1:0] req_data = 0;
  logic [7:0] act_sel_activation;
  logic [DW-1:0] act_alpha, act_in_feature, act_feature, out_data;
  logic [TW-1:0] out_tag;
  int total = 0, bad = 0, cyc = 0, first_pop = -1, last_pop = 0, first_iss = -1, done_cyc = 0, last_ov = 0, busy_gap = 0;
  logic [DW-1:0] rowq [N][$];
  logic [DW+TW-1:0] exp_out [$];
  int exp_gnt [$];

  activation_drain_scheduler dut (
    .core_clk(core_clk), .resetn(resetn), .start(start),
    .cfg_sel_activation(cfg_sel_activation), .cfg_alpha(cfg_alpha), .cfg_total_features(cfg_total_features),
    .busy(busy), .done(done), .cfg_error(cfg_error),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .act_sel_activation(act_sel_activation), .act_alpha(act_alpha),
    .act_in_feature_valid(act_in_feature_valid), .act_in_feature(act_in_feature),
    .act_feature_valid(act_feature_valid), .act_feature(act_feature),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag)
  );

  always #5 core_clk = ~core_clk;
  always @(posedge core_clk) cyc <= cyc + 1;

  // core model: sel 1 is ReLU, anything else passes through
  always @(posedge core_clk or negedge resetn)
    if (!resetn) begin
      act_feature_valid <= 1'b0;
      act_feature <= '0;
    end else begin
      act_feature_valid <= act_in_feature_valid;
      act_feature <= (act_sel_activation == 8'd1 && act_in_feature[DW-1]) ? '0 : act_in_feature;
    end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  // row drivers: each row presents the head of its queue until it is granted
  always begin
    @(negedge core_clk);
    taken = req_valid & req_ready;
    @(posedge core_clk);
    #2;
    for (int i = 0; i < N; i++) begin
      if (taken[i] && rowq[i].size() != 0) void'(rowq[i].pop_front());
      req_valid[i] = rowq[i].size() != 0;
      req_data[i*DW +: DW] = rowq[i].size() != 0 ? rowq[i][0] : '0;
    end
  end

  always @(negedge core_clk) begin
    if (resetn) begin
      if (|req_ready) begin
        if (first_iss < 0) first_iss = cyc;
        if (exp_gnt.size() == 0) begin
          total++;
          bad++;
          $display("FAIL grant: unexpected req_ready %b", req_ready);
        end else begin
          int e;
          e = exp_gnt.pop_front();
          check("grant", 64'(req_ready), 64'(N'(1) << e));
          check("issue_strobe", 64'(act_in_feature_valid), 64'd1);
          check("issue_data", 64'(act_in_feature), 64'(req_data[e*DW +: DW]));
        end
      end
      if (out_valid) last_ov = cyc;
      if (out_valid && out_ready) begin
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
        if (exp_out.size() == 0) begin
          total++;
          bad++;
          $display("FAIL out: unexpected data %0h tag %0d", out_data, out_tag);
        end else check("out", 64'({out_data, out_tag}), 64'(exp_out.pop_front()));
      end
    end
  end

  task automatic tick;
    @(posedge core_clk);
    #1;
  endtask

  task automatic start_layer(input logic [7:0] s, input logic [DW-1:0] a, input logic [CW-1:0] n);
    cfg_sel_activation = s;
    cfg_alpha = a;
    cfg_total_features = n;
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic wait_done(input int max);
    int n = 0;
    busy_gap = 0;
    @(negedge core_clk);
    while (!done && n < max) begin
      if (!busy) busy_gap++;
      n++;
      @(negedge core_clk);
    end
    check("done_seen", 64'(done), 64'd1);
    done_cyc = cyc;
    @(negedge core_clk);
    check("done_pulse_end", 64'({done, busy}), 64'd0);
    tick();
  endtask

  task automatic do_reset;
    resetn = 0;
    for (int i = 0; i < N; i++) rowq[i].delete();
    exp_out.delete();
    exp_gnt.delete();
    tick();
    tick();
    resetn = 1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n_done;
    out_ready = 1;
    repeat (2) @(negedge core_clk);
    check("rst_state", 64'({busy, done, cfg_error, out_valid, act_in_feature_valid, req_ready}), 64'd0);
    check("rst_cfg", 64'({act_sel_activation, act_alpha}), 64'd0);
    tick();
    resetn = 1;
    tick();
    // layer 1: ReLU on row 0 alone
    foreach (exp_gnt[i]) ;
    rowq[0].push_back(32'd5);
    rowq[0].push_back(32'hFFFF_FFFD);
    rowq[0].push_back(32'd7);
    rowq[0].push_back(32'hFFFF_FFFF);
    repeat (4) exp_gnt.push_back(0);
    exp_out.push_back({32'd5, 2'd0});
    exp_out.push_back({32'd0, 2'd0});
    exp_out.push_back({32'd7, 2'd0});
    exp_out.push_back({32'd0, 2'd0});
    first_iss = -1;
    first_pop = -1;
    tick();
    start_layer(8'd1, 32'h100, 16'd4);
    wait_done(30);
    check("t1_busy_gap", 64'(busy_gap), 64'd0);
    check("t1_done_lat", 64'(done_cyc - last_ov), 64'd1);
    check("t1_first_out_lat", 64'(first_pop - first_iss), 64'd2);
    check("t1_drained", 64'(exp_out.size() + exp_gnt.size()), 64'd0);
    check("t1_cfg", 64'({act_sel_activation, act_alpha}), 64'({8'd1, 32'h100}));
    // layer 2: all rows valid, round-robin at full rate
    do_reset();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < N; i++) begin
        rowq[i].push_back(DW'(100 + 10 * i + k));
        exp_gnt.push_back(i);
        exp_out.push_back({DW'(100 + 10 * i + k), TW'(i)});
      end
    first_pop = -1;
    tick();
    start_layer(8'd0, 32'd0, 16'd8);
    wait_done(40);
    check("t2_rate", 64'(last_pop - first_pop), 64'd7);
    check("t2_drained", 64'(exp_out.size() + exp_gnt.size()), 64'd0);
    // layer 3: downstream stall mid-layer
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      rowq[2].push_back(DW'(k));
      exp_gnt.push_back(2);
      exp_out.push_back({DW'(k), 2'd2});
    end
    tick();
    start_layer(8'd0, 32'd0, 16'd6);
    tick();
    tick();
    out_ready = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge core_clk);
      if (c >= 2) check("t3_stall", 64'({req_ready, out_valid}), 64'd1);
      tick();
    end
    out_ready = 1;
    wait_done(40);
    check("t3_drained", 64'(exp_out.size() + exp_gnt.size()), 64'd0);
    // rejected start, then a start ignored while active
    rowq[0].push_back(32'd9);
    tick();
    start_layer(8'd3, 32'h55, 16'd4);
    @(negedge core_clk);
    check("t4_cfg_error", 64'({cfg_error, busy, req_ready}), 64'b100000);
    check("t4_rej_cfg", 64'({act_sel_activation, act_alpha}), 64'd0);
    tick();
    @(negedge core_clk);
    check("t4_err_clear", 64'({cfg_error, busy, req_ready}), 64'd0);
    tick();
    repeat (3) exp_gnt.push_back(0);
    exp_out.push_back({32'd9, 2'd0});
    exp_out.push_back({32'd0, 2'd0});
    exp_out.push_back({32'd6, 2'd0});
    start_layer(8'd1, 32'h1234, 16'd3);
    repeat (4) tick();
    start_layer(8'd2, 32'hDEAD, 16'd1);
    @(negedge core_clk);
    check("t4_ignored", 64'({act_sel_activation, act_alpha, busy, cfg_error}), 64'({8'd1, 32'h1234, 1'b1, 1'b0}));
    tick();
    rowq[0].push_back(32'hFFFF_FFFC);
    rowq[0].push_back(32'd6);
    wait_done(30);
    check("t4_cfg_hold", 64'({act_sel_activation, act_alpha}), 64'({8'd1, 32'h1234}));
    check("t4_drained", 64'(exp_out.size() + exp_gnt.size()), 64'd0);
    // zero-length layer, then reset with results buffered
    rowq[1].push_back(32'd77);
    tick();
    start_layer(8'd0, 32'd0, 16'd0);
    @(negedge core_clk);
    check("t5_zero_done", 64'({done, busy, req_ready}), 64'b100000);
    tick();
    @(negedge core_clk);
    check("t5_zero_idle", 64'({done, busy, req_ready}), 64'd0);
    tick();
    rowq[1].delete();
    out_ready = 0;
    for (int k = 1; k <= 4; k++) rowq[0].push_back(DW'(k));
    repeat (2) exp_gnt.push_back(0);
    tick();
    start_layer(8'd0, 32'd0, 16'd4);
    repeat (4) tick();
    @(negedge core_clk);
    check("t5_buffered", 64'({out_valid, busy}), 64'b11);
    check("t5_grants_used", 64'(exp_gnt.size()), 64'd0);
    @(posedge core_clk);
    #1;
    resetn = 0;
    #1;
    check("t5_reset_now", 64'({out_valid, busy, done}), 64'd0);
    for (int i = 0; i < N; i++) rowq[i].delete();
    exp_out.delete();
    exp_gnt.delete();
    tick();
    resetn = 1;
    out_ready = 1;
    n_done = 0;
    repeat (4) begin
      @(negedge core_clk);
      if (done) n_done++;
    end
    check("t5_no_done", 64'(n_done), 64'd0);
    tick();
    // park the pointer on row 1, then rows 1 and 3 compete
    rowq[1].push_back(32'd50);
    exp_gnt.push_back(1);
    exp_out.push_back({32'd50, 2'd1});
    tick();
    start_layer(8'd0, 32'd0, 16'd1);
    wait_done(20);
    rowq[1].push_back(32'd61);
    rowq[1].push_back(32'd62);
    rowq[3].push_back(32'd81);
    rowq[3].push_back(32'd82);
    exp_gnt.push_back(3);
    exp_gnt.push_back(1);
    exp_gnt.push_back(3);
    exp_out.push_back({32'd81, 2'd3});
    exp_out.push_back({32'd61, 2'd1});
    exp_out.push_back({32'd82, 2'd3});
    tick();
    start_layer(8'd0, 32'd0, 16'd3);
    wait_done(20);
    rowq[1].delete();
    check("t6_drained", 64'(exp_out.size() + exp_gnt.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
